// File: rtl/adc_spi_controller.sv
// adc_spi_controller: SPI front end for the multi-lane SAR ADC.
//
// Runs two kinds of SPI transfer on one bus:
//   - conversion reads, started by the trigger input; NUM_SDI lanes are
//     shifted in per SCK period and optionally summed over 2^AVG_LOG2 frames;
//   - 24-bit register transactions, taken from the command stream; read
//     commands return one byte on the readback stream.
// SCK is produced in fabric from a counter that divides aclk.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   trigger               conversion request, level-sampled in IDLE
//   spi_sdi/sdo/csn/sck   ADC serial bus; spi_resetn mirrors ~areset
//   s_axis_*              register command stream (tdata[23:0] used)
//   m_axis_cnv_*          conversion result stream (OUT_WIDTH bits)
//   m_axis_reg_*          register readback stream (8 bits)
//   status                {overrun[15:0], 10'b0, reg_tvalid, cnv_tvalid,
//                          mode[1:0], pending, busy}
module adc_spi_controller #(
    parameter int unsigned NUM_SDI      = 4,
    parameter int unsigned SAMPLE_WIDTH = 32,
    parameter int unsigned SCK_DIV      = 1,
    parameter int unsigned AVG_LOG2     = 0,
    parameter int unsigned OUT_WIDTH    = SAMPLE_WIDTH + AVG_LOG2
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 trigger,
    input  logic [NUM_SDI-1:0]   spi_sdi,
    output logic                 spi_sdo,
    output logic                 spi_csn,
    output logic                 spi_sck,
    output logic                 spi_resetn,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_cnv_tdata,
    output logic                 m_axis_cnv_tvalid,
    input  logic                 m_axis_cnv_tready,
    output logic [7:0]           m_axis_reg_tdata,
    output logic                 m_axis_reg_tvalid,
    input  logic                 m_axis_reg_tready,
    output logic [31:0]          status
);

    localparam int unsigned NCYC_CNV = SAMPLE_WIDTH / NUM_SDI;
    localparam int unsigned NCYC_REG = 24;
    localparam int unsigned NCYC_MAX = (NCYC_CNV > NCYC_REG) ? NCYC_CNV : NCYC_REG;
    localparam int unsigned BIT_W    = $clog2(NCYC_MAX);
    localparam int unsigned DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned FCNT_W   = AVG_LOG2 + 1;
    localparam int unsigned FRAMES   = 1 << AVG_LOG2;
    localparam int unsigned RB_FIRST = 16;

    localparam logic [1:0] MODE_CNV     = 2'b00;
    localparam logic [1:0] MODE_ONCE    = 2'b01;
    localparam logic [1:0] MODE_PERSIST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Control strobes decoded by the FSM
    logic start_cnv, start_reg, sck_rise, sck_fall, done, tick;

    // Datapath registers
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    is_reg;
    logic                    pending;
    logic [1:0]              mode;
    logic [23:0]             cmd;
    logic [23:0]             tx_sh;
    logic [SAMPLE_WIDTH-1:0] frame;
    logic [7:0]              readback;
    logic [OUT_WIDTH-1:0]    acc;
    logic [FCNT_W-1:0]       fcnt;
    logic [15:0]             overrun;
    logic                    busy;

    logic                    cmd_hs, pending_nxt;
    logic [BIT_W-1:0]        last_bit;
    logic                    cnv_done, reg_done, frame_done;
    logic                    trig_ovr, cnv_drop, reg_over;
    logic [1:0]              ovr_inc;
    logic [16:0]             ovr_sum;
    logic [OUT_WIDTH-1:0]    acc_sum;
    logic                    unused_ok;

    assign spi_resetn = ~areset;
    assign status     = {overrun, 10'b0, m_axis_reg_tvalid, m_axis_cnv_tvalid, mode, pending, busy};
    assign unused_ok  = &{1'b0, s_axis_tdata[31:24]};

    assign cmd_hs      = s_axis_tvalid && s_axis_tready;
    assign pending_nxt = (pending || cmd_hs) && !start_reg;
    assign last_bit    = is_reg ? BIT_W'(NCYC_REG - 1) : BIT_W'(NCYC_CNV - 1);

    assign cnv_done   = done && !is_reg;
    assign reg_done   = done && is_reg;
    assign frame_done = (fcnt == FCNT_W'(FRAMES - 1));
    assign acc_sum    = acc + OUT_WIDTH'(frame);

    // A new result that finds the previous one still stalled is an overrun
    assign cnv_drop = cnv_done && frame_done && m_axis_cnv_tvalid && !m_axis_cnv_tready;
    assign reg_over = reg_done && cmd[23] && m_axis_reg_tvalid && !m_axis_reg_tready;
    assign trig_ovr = trigger && (state != ST_IDLE);
    assign ovr_inc  = 2'(trig_ovr) + 2'(cnv_drop) + 2'(reg_over);
    assign ovr_sum  = 17'(overrun) + 17'(ovr_inc);

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbitration and SCK phase strobes
    always_comb begin
        state_nxt = state;
        start_cnv = 1'b0;
        start_reg = 1'b0;
        sck_rise  = 1'b0;
        sck_fall  = 1'b0;
        done      = 1'b0;
        tick      = (div_cnt == DIV_W'(SCK_DIV - 1));
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    start_reg = 1'b1;
                    state_nxt = ST_SHIFT;
                end else if (trigger && (mode == MODE_CNV)) begin
                    start_cnv = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!spi_sck) begin
                        sck_rise = 1'b1;
                    end else begin
                        sck_fall = 1'b1;
                        if (bit_cnt == last_bit) begin
                            state_nxt = ST_TAIL;
                        end
                    end
                end
            end
            ST_TAIL: begin
                // One trailing sck-low cycle with csn still asserted
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus timing, shift registers, command intake, mode tracking
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            spi_csn       <= 1'b1;
            spi_sck       <= 1'b0;
            spi_sdo       <= 1'b0;
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
            pending       <= 1'b0;
            mode          <= MODE_CNV;
            cmd           <= '0;
            tx_sh         <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            is_reg        <= 1'b0;
            frame         <= '0;
            readback      <= '0;
        end else begin
            s_axis_tready <= (state_nxt == ST_IDLE) && !pending_nxt;
            busy          <= (state_nxt != ST_IDLE);
            pending       <= pending_nxt;

            if (cmd_hs) begin
                cmd <= s_axis_tdata[23:0];
                if (mode != MODE_PERSIST) begin
                    mode <= MODE_ONCE;
                end
            end

            if (start_cnv || start_reg) begin
                spi_csn <= 1'b0;
                spi_sck <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                is_reg  <= start_reg;
                // Register frames put bit 23 on sdo as csn falls
                tx_sh   <= start_reg ? cmd : 24'h0;
                spi_sdo <= start_reg && cmd[23];
            end

            if (state == ST_SHIFT) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    spi_sck <= ~spi_sck;
                end
            end

            if (sck_rise) begin
                if (!is_reg) begin
                    frame <= (frame << NUM_SDI) | SAMPLE_WIDTH'(spi_sdi);
                end else if (bit_cnt >= BIT_W'(RB_FIRST)) begin
                    readback <= {readback[6:0], spi_sdi[0]};
                end
            end

            // Zeros shift in behind the command, so sdo idles low after bit 0
            if (sck_fall) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                tx_sh   <= tx_sh << 1;
                spi_sdo <= tx_sh[22];
            end

            if (done) begin
                spi_csn <= 1'b1;
            end

            if (reg_done) begin
                if (cmd[23:21] == 3'b101) begin
                    mode <= MODE_PERSIST;
                end else if ((cmd == 24'h001401) || (mode == MODE_ONCE)) begin
                    mode <= MODE_CNV;
                end
            end
        end
    end

    // Accumulator and result streams
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc               <= '0;
            fcnt              <= '0;
            m_axis_cnv_tdata  <= '0;
            m_axis_cnv_tvalid <= 1'b0;
            m_axis_reg_tdata  <= '0;
            m_axis_reg_tvalid <= 1'b0;
            overrun           <= '0;
        end else begin
            overrun <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];

            if (m_axis_cnv_tvalid && m_axis_cnv_tready) begin
                m_axis_cnv_tvalid <= 1'b0;
            end
            if (cnv_done) begin
                if (frame_done) begin
                    acc  <= '0;
                    fcnt <= '0;
                    if (!cnv_drop) begin
                        m_axis_cnv_tdata  <= acc_sum;
                        m_axis_cnv_tvalid <= 1'b1;
                    end
                end else begin
                    acc  <= acc_sum;
                    fcnt <= fcnt + FCNT_W'(1);
                end
            end

            if (m_axis_reg_tvalid && m_axis_reg_tready) begin
                m_axis_reg_tvalid <= 1'b0;
            end
            if (reg_done && cmd[23]) begin
                m_axis_reg_tdata  <= readback;
                m_axis_reg_tvalid <= 1'b1;
            end
        end
    end

endmodule
